// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Types and constants local to the hazard controller.
//               hazard_state_t : RUN / MULDIV / DROP sequencing state
//               c_perf_w       : width of the performance counters
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    localparam int c_perf_w = 32;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        MULDIV = 2'd1,
        DROP   = 2'd2
    } hazard_state_t;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/pipes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipes_pkg
// Description : Shared pipeline-register control types. Each struct carries
//               one enable per pipeline register, packed {fd,de,em,mw}, with
//               fd in the most significant bit.
//               regstall_en_t : 1 = the register holds its value
//               regflush_en_t : 1 = the register loads a bubble
// Revision    : 1.0 - initial release
// ============================================================================
package pipes_pkg;

    typedef struct packed {
        logic fd;
        logic de;
        logic em;
        logic mw;
    } regstall_en_t;

    typedef struct packed {
        logic fd;
        logic de;
        logic em;
        logic mw;
    } regflush_en_t;

endpackage : pipes_pkg
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_if
// Description : Bundle between the datapath and the hazard controller.
//   Events (datapath -> controller):
//     i_wait, d_wait, load_use, md_start, redirect, trap
//   Controls (controller -> datapath):
//     pc_stall, redirect_hold, stall{fd,de,em,mw}, flush{fd,de,em,mw},
//     md_busy, perf_stall_cyc[31:0], perf_flush_evt[31:0]
//   Modports: master = datapath side, slave = controller side.
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if;
    import pipes_pkg::*;
    import hazard_pkg::*;

    logic                i_wait;
    logic                d_wait;
    logic                load_use;
    logic                md_start;
    logic                redirect;
    logic                trap;

    logic                pc_stall;
    logic                redirect_hold;
    regstall_en_t        stall;
    regflush_en_t        flush;
    logic                md_busy;
    logic [c_perf_w-1:0] perf_stall_cyc;
    logic [c_perf_w-1:0] perf_flush_evt;

    modport master (
        output i_wait, d_wait, load_use, md_start, redirect, trap,
        input  pc_stall, redirect_hold, stall, flush, md_busy,
               perf_stall_cyc, perf_flush_evt
    );

    modport slave (
        input  i_wait, d_wait, load_use, md_start, redirect, trap,
        output pc_stall, redirect_hold, stall, flush, md_busy,
               perf_stall_cyc, perf_flush_evt
    );

endinterface : hazard_ctrl_if
`default_nettype wire

// File: rtl/hazard_perf_cnt.sv
`default_nettype none
// ============================================================================
// Module      : hazard_perf_cnt
// Description : Two free-running wrap-around hazard event counters.
//   clk            : clock, rising edge
//   reset          : synchronous, active-low
//   stall_inc      : count this cycle as a PC-stall cycle
//   evt_inc        : count one accepted redirect/trap event
//   perf_stall_cyc : stall-cycle count
//   perf_flush_evt : flush-event count
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_perf_cnt
    import hazard_pkg::*;
(
    input  wire logic                clk,
    input  wire logic                reset,
    input  wire logic                stall_inc,
    input  wire logic                evt_inc,
    output logic [c_perf_w-1:0]      perf_stall_cyc,
    output logic [c_perf_w-1:0]      perf_flush_evt
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_stall_cyc <= '0;
            perf_flush_evt <= '0;
        end else begin
            perf_stall_cyc <= perf_stall_cyc + {{(c_perf_w-1){1'b0}}, stall_inc};
            perf_flush_evt <= perf_flush_evt + {{(c_perf_w-1){1'b0}}, evt_inc};
        end
    end

endmodule : hazard_perf_cnt
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Central hazard controller for the 5-stage pipeline. Turns
//               datapath wait/dependency/redirect events into stall and
//               flush vectors for fd/de/em/mw plus the PC hold, sequencing
//               multi-cycle mul/div occupancy and wrong-path fetch discard.
//   clk   : clock, rising edge
//   reset : synchronous, active-low
//   hz    : hazard_ctrl_if.slave (events in, controls/perf counters out)
//   MULDIV_LAT : extra execute cycles a mul/div occupies (>= 1)
//   Optional macro HAZARD_PERF_EN instantiates the perf counters; without
//   it both perf outputs are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import pipes_pkg::*;
    import hazard_pkg::*;
#(
    parameter int MULDIV_LAT = 64
)(
    input  wire logic     clk,
    input  wire logic     reset,
    hazard_ctrl_if.slave  hz
);

    localparam int                 c_cnt_w    = $clog2(MULDIV_LAT + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(MULDIV_LAT - 1);

    hazard_state_t       r_state;
    hazard_state_t       w_state_n;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_cnt_w-1:0]  w_cnt_n;

    logic                w_pc_stall;
    logic                w_redirect_hold;
    regstall_en_t        w_stall;
    regflush_en_t        w_flush;
    logic                w_md_busy;
    logic                w_flush_evt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
        end
    end

    always_comb begin
        w_pc_stall      = 1'b0;
        w_redirect_hold = 1'b0;
        w_stall         = '0;
        w_flush         = '0;
        w_md_busy       = 1'b0;
        w_flush_evt     = 1'b0;
        w_state_n       = r_state;
        w_cnt_n         = r_cnt;

        case (r_state)
            RUN: begin
                if (hz.d_wait) begin
                    w_pc_stall = 1'b1;
                    w_stall    = '{fd: 1'b1, de: 1'b1, em: 1'b1, mw: 1'b0};
                    w_flush.mw = 1'b1;
                end else if (hz.trap) begin
                    w_flush     = '{fd: 1'b1, de: 1'b1, em: 1'b1, mw: 1'b0};
                    w_flush_evt = 1'b1;
                    w_state_n   = hz.i_wait ? DROP : RUN;
                end else if (hz.md_start) begin
                    w_pc_stall = 1'b1;
                    w_stall.fd = 1'b1;
                    w_stall.de = 1'b1;
                    w_flush.em = 1'b1;
                    w_cnt_n    = c_cnt_load;
                    w_state_n  = MULDIV;
                end else if (hz.redirect) begin
                    w_flush.fd  = 1'b1;
                    w_flush.de  = 1'b1;
                    w_flush_evt = 1'b1;
                    // The wrong-path fetch is still in flight: park the
                    // target and wait for that fetch to come back.
                    if (hz.i_wait) begin
                        w_redirect_hold = 1'b1;
                        w_pc_stall      = 1'b1;
                        w_state_n       = DROP;
                    end
                end else if (hz.load_use) begin
                    w_pc_stall = 1'b1;
                    w_stall.fd = 1'b1;
                    w_flush.de = 1'b1;
                end else if (hz.i_wait) begin
                    w_pc_stall = 1'b1;
                    w_flush.fd = 1'b1;
                end
            end

            MULDIV: begin
                w_md_busy = 1'b1;
                if (r_cnt != '0) begin
                    w_cnt_n = r_cnt - c_cnt_w'(1);
                end
                // A pending data access freezes em/mw regardless of the
                // counter; the writeback trap is only taken once mem is free,
                // matching the RUN-state ordering.
                if (hz.d_wait) begin
                    w_pc_stall = 1'b1;
                    w_stall    = '{fd: 1'b1, de: 1'b1, em: 1'b1, mw: 1'b0};
                    w_flush.mw = 1'b1;
                end else if (hz.trap) begin
                    w_flush     = '{fd: 1'b1, de: 1'b1, em: 1'b1, mw: 1'b0};
                    w_md_busy   = 1'b0;
                    w_flush_evt = 1'b1;
                    w_state_n   = hz.i_wait ? DROP : RUN;
                end else if (r_cnt == '0) begin
                    // Result ready: de releases it into em this cycle.
                    w_state_n = RUN;
                end else begin
                    w_pc_stall = 1'b1;
                    w_stall.fd = 1'b1;
                    w_stall.de = 1'b1;
                    w_flush.em = 1'b1;
                end
            end

            DROP: begin
                w_pc_stall = 1'b1;
                w_flush.fd = 1'b1;
                if (hz.trap) begin
                    w_flush.de  = 1'b1;
                    w_flush.em  = 1'b1;
                    w_flush_evt = 1'b1;
                end else if (!hz.i_wait) begin
                    // Stale instruction returns now and is bubbled; PC takes
                    // the pending target.
                    w_pc_stall = 1'b0;
                    w_state_n  = RUN;
                end
            end

            default: begin
                w_state_n = RUN;
            end
        endcase

        // While in reset every register is bubbled and nothing is counted.
        if (!reset) begin
            w_pc_stall      = 1'b0;
            w_redirect_hold = 1'b0;
            w_stall         = '0;
            w_flush         = '1;
            w_md_busy       = 1'b0;
            w_flush_evt     = 1'b0;
        end
    end

    assign hz.pc_stall      = w_pc_stall;
    assign hz.redirect_hold = w_redirect_hold;
    assign hz.stall         = w_stall;
    assign hz.flush         = w_flush;
    assign hz.md_busy       = w_md_busy;

`ifdef HAZARD_PERF_EN
    hazard_perf_cnt u_perf (
        .clk            (clk),
        .reset          (reset),
        .stall_inc      (w_pc_stall),
        .evt_inc        (w_flush_evt),
        .perf_stall_cyc (hz.perf_stall_cyc),
        .perf_flush_evt (hz.perf_flush_evt)
    );
`else
    logic perf_unused;
    assign perf_unused       = &{1'b0, w_flush_evt};
    assign hz.perf_stall_cyc = '0;
    assign hz.perf_flush_evt = '0;
`endif

endmodule : hazard_ctrl
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Scoreboard bench for hazard_ctrl. A stimulus process drives
//               directed and random events, computes the expected response
//               from a behavioural model of the hazard rules and queues it;
//               a monitor pops and compares on each falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int LAT = 3;

    typedef struct packed {
        logic [10:0] ctl;   // {pc_stall, redirect_hold, stall[3:0], flush[3:0], md_busy}
        logic [31:0] ps;
        logic [31:0] pf;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_ctrl_if hz();

    hazard_ctrl #(.MULDIV_LAT(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // ---------------- behavioural model ----------------
    // mode: 0 normal flow, 1 mul/div in execute, 2 discarding stale fetch
    int          m_mode = 0;
    int          m_left = 0;      // busy cycles remaining before the release cycle
    logic [31:0] m_stall_cnt = '0;
    logic [31:0] m_evt_cnt   = '0;

    task automatic model(input logic rst_n, iw, dw, lu, ms, rd, tr, output exp_t e);
        logic       pc, rh, busy, evt;
        logic [3:0] st, fl;       // bit3 = fd ... bit0 = mw
        int         nxt;
        pc = 0; rh = 0; busy = 0; evt = 0; st = 4'b0000; fl = 4'b0000;
        nxt = m_mode;
        if (!rst_n) begin
            fl = 4'b1111;
        end else if (m_mode == 0) begin
            if (dw)      begin pc = 1; st = 4'b1110; fl = 4'b0001; end
            else if (tr) begin fl = 4'b1110; evt = 1; nxt = iw ? 2 : 0; end
            else if (ms) begin pc = 1; st = 4'b1100; fl = 4'b0010; nxt = 1; m_left = LAT - 1; end
            else if (rd) begin fl = 4'b1100; evt = 1; if (iw) begin rh = 1; pc = 1; nxt = 2; end end
            else if (lu) begin pc = 1; st = 4'b1000; fl = 4'b0100; end
            else if (iw) begin pc = 1; fl = 4'b1000; end
        end else if (m_mode == 1) begin
            busy = 1;
            if (dw)                begin pc = 1; st = 4'b1110; fl = 4'b0001; end
            else if (tr)           begin fl = 4'b1110; busy = 0; evt = 1; nxt = iw ? 2 : 0; end
            else if (m_left == 0)  begin nxt = 0; end
            else                   begin pc = 1; st = 4'b1100; fl = 4'b0010; end
            if (m_left > 0) m_left = m_left - 1;
        end else begin
            pc = 1; fl = 4'b1000;
            if (tr)       begin fl = 4'b1110; evt = 1; end
            else if (!iw) begin pc = 0; nxt = 0; end
        end

        e.ctl = {pc, rh, st, fl, busy};
`ifdef HAZARD_PERF_EN
        e.ps = m_stall_cnt;
        e.pf = m_evt_cnt;
`else
        e.ps = '0;
        e.pf = '0;
`endif
        if (!rst_n) begin
            m_mode = 0; m_left = 0; m_stall_cnt = '0; m_evt_cnt = '0;
        end else begin
            m_mode = nxt;
            m_stall_cnt = m_stall_cnt + {31'b0, pc};
            m_evt_cnt   = m_evt_cnt + {31'b0, evt};
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic cyc(input logic rst_n, iw, dw, lu, ms, rd, tr);
        exp_t e;
        @(posedge clk);
        #1;
        reset       = rst_n;
        hz.i_wait   = iw;
        hz.d_wait   = dw;
        hz.load_use = lu;
        hz.md_start = ms;
        hz.redirect = rd;
        hz.trap     = tr;
        model(rst_n, iw, dw, lu, ms, rd, tr, e);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        logic [10:0] act;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {hz.pc_stall, hz.redirect_hold, hz.stall, hz.flush, hz.md_busy};
            n_checks++;
            if (act === e.ctl) n_pass++;
            else $display("FAIL ctl t=%0t actual=%b required=%b", $time, act, e.ctl);
            n_checks++;
            if (hz.perf_stall_cyc === e.ps && hz.perf_flush_evt === e.pf) n_pass++;
            else $display("FAIL perf t=%0t actual=%0d/%0d required=%0d/%0d",
                          $time, hz.perf_stall_cyc, hz.perf_flush_evt, e.ps, e.pf);
        end
    end

    initial begin
        reset = 1'b0;
        hz.i_wait = 0; hz.d_wait = 0; hz.load_use = 0;
        hz.md_start = 0; hz.redirect = 0; hz.trap = 0;

        // reset state
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 1, 1, 1, 1);
        idle(2);
        // load-use: one bubble
        cyc(1, 0, 0, 1, 0, 0, 0);
        idle(1);
        // mul/div with no memory wait
        cyc(1, 0, 0, 0, 1, 0, 0);
        idle(5);
        // redirect while the fetch is outstanding for 3 more cycles
        cyc(1, 1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0, 0, 0);
        idle(2);
        // redirect with no fetch outstanding
        cyc(1, 0, 0, 0, 0, 1, 0);
        idle(1);
        // d_wait while the mul/div counter reaches zero and beyond
        cyc(1, 0, 0, 0, 1, 0, 0);
        idle(1);
        for (int i = 0; i < 4; i++) cyc(1, 0, 1, 0, 0, 0, 0);
        idle(2);
        // trap on the first MULDIV cycle
        cyc(1, 0, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 1);
        idle(2);
        // trap with fetch outstanding -> DROP, then reset mid-DROP
        cyc(1, 1, 0, 0, 0, 0, 1);
        cyc(1, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        idle(2);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(99) != 0),
                ($urandom_range(99) < 35),
                ($urandom_range(99) < 15),
                ($urandom_range(99) < 15),
                ($urandom_range(99) < 12),
                ($urandom_range(99) < 15),
                ($urandom_range(99) < 5));
        end
        idle(2);

        // drain: bounded wait for the monitor to consume everything
        for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain actual=%0d pending required=0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_hazard_ctrl
`default_nettype wire
